vga_timing_gen: RTL and testbench

- Generates 640x480@60 Hz VGA timing for the display path.
- Runs on the single 100 MHz board clock and derives a pixel-rate clock enable internally. No divided clock is used as a clock.
- Sits between the board clock/reset and the pixel renderer. Downstream logic consumes pixel_x/pixel_y/video_on qualified by pixel_tick, and uses frame_tick for per-frame game updates.

---
 rtl/vga_timing_pkg.sv | 24 ++
 rtl/vga_timing_gen_tick_gen.sv | 44 ++++
 rtl/vga_timing_gen.sv | 103 ++++++++++
 tb/tb_vga_timing_gen.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 VGA timing constants. Sub-blocks and the top take these as
// parameter defaults so that reduced-size builds can reuse the same code.
package vga_timing_pkg;

  localparam int COORD_W = 10;

  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;

  localparam int VGA_H_TOTAL = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
  localparam int VGA_V_TOTAL = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

  localparam int VGA_H_SYNC_START = VGA_H_ACTIVE + VGA_H_FP;
  localparam int VGA_H_SYNC_END   = VGA_H_SYNC_START + VGA_H_SYNC;
  localparam int VGA_V_SYNC_START = VGA_V_ACTIVE + VGA_V_FP;
  localparam int VGA_V_SYNC_END   = VGA_V_SYNC_START + VGA_V_SYNC;

endpackage

// File: rtl/vga_timing_gen_tick_gen.sv
// Divide-by-DIV counter. `wrap` marks the edge on which the enable fires;
// `tick` is the registered one-cycle enable visible in the following cycle.
module tick_gen #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  output logic wrap,
  output logic tick
);

  localparam int CW = $clog2(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  if (DIV < 2) begin : g_bad_div
    $error("tick_gen: DIV must be >= 2");
  end

  logic [CW-1:0] cnt_q, cnt_d;
  logic          tick_q, tick_d;

  // NOTE: every always_comb output gets a value on every path (here by plain
  // assignment); a missing default would infer a latch.
  always_comb begin
    wrap   = (cnt_q == LAST);
    cnt_d  = wrap ? '0 : cnt_q + CW'(1);
    tick_d = wrap;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing on the board clock with an internal pixel-rate enable.
// All outputs are decoded from the next-state counts, so they change together.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int   DIV      = 4,
  parameter int   H_ACTIVE = VGA_H_ACTIVE,
  parameter int   H_FP     = VGA_H_FP,
  parameter int   H_SYNC   = VGA_H_SYNC,
  parameter int   H_BP     = VGA_H_BP,
  parameter int   V_ACTIVE = VGA_V_ACTIVE,
  parameter int   V_FP     = VGA_V_FP,
  parameter int   V_SYNC   = VGA_V_SYNC,
  parameter int   V_BP     = VGA_V_BP,
  parameter logic SYNC_POL = 1'b0
) (
  input  logic               boardCLK,
  input  logic               reset,
  output logic               pixel_tick,
  output logic [COORD_W-1:0] pixel_x,
  output logic [COORD_W-1:0] pixel_y,
  output logic               video_on,
  output logic               hsync,
  output logic               vsync,
  output logic               frame_tick
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  if (H_TOTAL > (1 << COORD_W) || V_TOTAL > (1 << COORD_W)) begin : g_bad_size
    $error("vga_timing_gen: H_TOTAL/V_TOTAL exceed the coordinate width");
  end

  localparam logic [COORD_W-1:0] H_LAST   = COORD_W'(H_TOTAL - 1);
  localparam logic [COORD_W-1:0] V_LAST   = COORD_W'(V_TOTAL - 1);
  localparam logic [COORD_W-1:0] H_VIS    = COORD_W'(H_ACTIVE);
  localparam logic [COORD_W-1:0] V_VIS    = COORD_W'(V_ACTIVE);
  localparam logic [COORD_W-1:0] HS_START = COORD_W'(H_ACTIVE + H_FP);
  localparam logic [COORD_W-1:0] HS_END   = COORD_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [COORD_W-1:0] VS_START = COORD_W'(V_ACTIVE + V_FP);
  localparam logic [COORD_W-1:0] VS_END   = COORD_W'(V_ACTIVE + V_FP + V_SYNC);

  logic adv;

  tick_gen #(.DIV(DIV)) u_pixel_tick (
    .clk  (boardCLK),
    .rst_n(reset),
    .wrap (adv),
    .tick (pixel_tick)
  );

  logic [COORD_W-1:0] h_cnt_q, h_cnt_d;
  logic [COORD_W-1:0] v_cnt_q, v_cnt_d;
  logic               video_on_q, video_on_d;
  logic               hsync_q, hsync_d;
  logic               vsync_q, vsync_d;
  logic               frame_tick_q, frame_tick_d;

  always_comb begin
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    if (adv) begin
      if (h_cnt_q == H_LAST) begin
        h_cnt_d = '0;
        v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + COORD_W'(1);
      end else begin
        h_cnt_d = h_cnt_q + COORD_W'(1);
      end
    end
    // Decode from the next-state counts so the flops below line up with them.
    video_on_d   = (h_cnt_d < H_VIS) && (v_cnt_d < V_VIS);
    hsync_d      = ((h_cnt_d >= HS_START) && (h_cnt_d < HS_END)) ? SYNC_POL : ~SYNC_POL;
    vsync_d      = ((v_cnt_d >= VS_START) && (v_cnt_d < VS_END)) ? SYNC_POL : ~SYNC_POL;
    frame_tick_d = adv && (h_cnt_d == '0) && (v_cnt_d == '0);
  end

  always_ff @(posedge boardCLK or negedge reset) begin
    if (!reset) begin
      h_cnt_q      <= '0;
      v_cnt_q      <= '0;
      video_on_q   <= 1'b1;
      hsync_q      <= ~SYNC_POL;
      vsync_q      <= ~SYNC_POL;
      frame_tick_q <= 1'b0;
    end else begin
      h_cnt_q      <= h_cnt_d;
      v_cnt_q      <= v_cnt_d;
      video_on_q   <= video_on_d;
      hsync_q      <= hsync_d;
      vsync_q      <= vsync_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign pixel_x    = h_cnt_q;
  assign pixel_y    = v_cnt_q;
  assign video_on   = video_on_q;
  assign hsync      = hsync_q;
  assign vsync      = vsync_q;
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench: a full-size DIV=4 build plus two reduced-raster builds
// (DIV=2, DIV=8) run side by side under random reset/run phases.
module tb_vga_timing_gen;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       von;
    logic       hs;
    logic       vs;
    logic       ft;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  for (genvar g = 0; g < 3; g++) begin : g_cfg
    localparam int  DV  = (g == 0) ? 4 : (g == 1) ? 2 : 8;
    localparam bit  BIG = (g == 0);
    localparam int  HA  = BIG ? 640 : 8;
    localparam int  HF  = BIG ? 16 : 2;
    localparam int  HS  = BIG ? 96 : 3;
    localparam int  HB  = BIG ? 48 : 3;
    localparam int  VA  = BIG ? 480 : 6;
    localparam int  VF  = BIG ? 10 : 1;
    localparam int  VS  = 2;
    localparam int  VB  = BIG ? 33 : 2;
    localparam int  HT  = HA + HF + HS + HB;
    localparam int  VT  = VA + VF + VS + VB;

    logic       pt, von, hs, vs, ft;
    logic [9:0] px, py;

    vga_timing_gen #(
      .DIV(DV), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
      .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .SYNC_POL(1'b0)
    ) dut (
      .boardCLK  (clk),
      .reset     (rst_n),
      .pixel_tick(pt),
      .pixel_x   (px),
      .pixel_y   (py),
      .video_on  (von),
      .hsync     (hs),
      .vsync     (vs),
      .frame_tick(ft)
    );

    // Raster position after t pixel periods, from the timing rules directly.
    function automatic exp_t ref_at(input int t);
      exp_t r;
      int p, x, y;
      p     = t % (HT * VT);
      x     = p % HT;
      y     = p / HT;
      r.x   = 10'(x);
      r.y   = 10'(y);
      r.von = (x < HA) && (y < VA);
      r.hs  = !((x >= HA + HF) && (x < HA + HF + HS));
      r.vs  = !((y >= VA + VF) && (y < VA + VF + VS));
      r.ft  = (p == 0);
      return r;
    endfunction

    exp_t q[$];
    int   n = 0;

    // Model: counts active edges since reset release; a tick is due every DV.
    always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        if (q.size() != 0)
          check($sformatf("g%0d missing ticks", g), q.size(), 0);
        q.delete();
        n = 0;
      end else begin
        n = n + 1;
        if (n % DV == 0) q.push_back(ref_at(n / DV));
      end
    end

    // Monitor: pops on every DUT pixel_tick, away from the active edge.
    always @(negedge clk) begin
      if (rst_n) begin
        if (pt) begin
          if (q.size() == 0) begin
            check($sformatf("g%0d unexpected tick", g), 32'd1, 32'd0);
          end else begin
            exp_t e;
            e = q.pop_front();
            check($sformatf("g%0d tick x=%0d y=%0d", g, e.x, e.y),
                  32'({px, py, von, hs, vs, ft}), 32'(e));
          end
        end else begin
          check($sformatf("g%0d frame_tick off-tick", g), 32'(ft), 32'd0);
        end
      end else begin
        check($sformatf("g%0d reset state", g),
              32'({pt, px, py, von, hs, vs, ft}), 32'({1'b0, 10'd0, 10'd0, 4'b1110}));
      end
    end

    // Reset takes effect without a clock edge.
    always @(negedge rst_n) begin
      #1;
      check($sformatf("g%0d async reset", g),
            32'({pt, px, py, von, hs, vs, ft}), 32'({1'b0, 10'd0, 10'd0, 4'b1110}));
    end
  end

  initial begin
    rst_n = 1'b0;
    repeat (10) @(posedge clk);
    #6 rst_n = 1'b1;
    // Several full-size lines and many reduced-size frames.
    repeat (14000) @(posedge clk);
    #6 rst_n = 1'b0;
    for (int r = 0; r < 4; r++) begin
      repeat ($urandom_range(12, 3)) @(posedge clk);
      #6 rst_n = 1'b1;
      repeat ($urandom_range(3000, 50)) @(posedge clk);
      #6 rst_n = 1'b0;
    end
    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
